// File: rtl/aes_mc_pkg.sv
// Shared GF(2^8) helpers, MixColumns coefficient sets and FSM states for the
// column-mixing engines.
package aes_mc_pkg;

  localparam logic [8:0] AES_POLY = 9'h11B;

  // Entry j is the row-0 coefficient applied to byte j (a = 0 .. d = 3).
  localparam logic [3:0][7:0] INV_COEF = {8'h09, 8'h0D, 8'h0B, 8'h0E};
  localparam logic [3:0][7:0] FWD_COEF = {8'h01, 8'h01, 8'h03, 8'h02};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY[7:0] : 8'h00);
  endfunction

  // Shift-and-add over an xtime chain; k is small so most terms vanish.
  function automatic logic [7:0] gf_mul_const(input logic [7:0] x, input logic [7:0] k);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = x;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/inv_mixcolumn_seq_if.sv
// Input/output handshake bundle for inv_mixcolumn_seq; the fwd direction
// select exists only when INV_MC_FWD_MODE_EN is defined.
interface inv_mixcolumn_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
`ifdef INV_MC_FWD_MODE_EN
  logic         fwd;
`endif

  modport slave (
    input  in_valid, state_in, out_ready,
`ifdef INV_MC_FWD_MODE_EN
    input  fwd,
`endif
    output in_ready, out_valid, state_out
  );

  modport master (
    output in_valid, state_in, out_ready,
`ifdef INV_MC_FWD_MODE_EN
    output fwd,
`endif
    input  in_ready, out_valid, state_out
  );
endinterface

// File: rtl/inv_mix_column_32bit.sv
// Combinational single-column InvMixColumns (forward MixColumns when fwd=1
// and INV_MC_FWD_MODE_EN is defined). Byte a = col[31:24] .. d = col[7:0].
module inv_mix_column_32bit
  import aes_mc_pkg::*;
(
  input  logic [31:0] col,
`ifdef INV_MC_FWD_MODE_EN
  input  logic        fwd,
`endif
  output logic [31:0] res
);

  logic            fwd_sel;
  logic [3:0][7:0] coef;

`ifdef INV_MC_FWD_MODE_EN
  assign fwd_sel = fwd;
`else
  assign fwd_sel = 1'b0;
`endif

  assign coef = fwd_sel ? FWD_COEF : INV_COEF;

  // Row r uses the row-0 coefficients rotated right by r (circulant matrix).
  always_comb begin
    logic [7:0] acc;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      acc = 8'h00;
      for (int j = 0; j < 4; j++) begin
        acc = acc ^ gf_mul_const(col[31-8*j -: 8], coef[2'(j - r)]);
      end
      res[31-8*r -: 8] = acc;
    end
  end

endmodule

// File: rtl/inv_mixcolumn_seq.sv
// Sequential InvMixColumns: COLS_PER_CYCLE columns per clock, latency 4/COLS_PER_CYCLE.
// No new input while busy or holding an unconsumed result; INV_MC_FWD_MODE_EN adds fwd.
module inv_mixcolumn_seq
  import aes_mc_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
)
(
  input  logic               clk,
  input  logic               rst_n,
  inv_mixcolumn_seq_if.slave mc
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
    $error("inv_mixcolumn_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

  mc_state_t    state_q;
  mc_state_t    state_d;
  logic [1:0]   col_cnt;
  logic [127:0] st_q;
  logic [1:0]   col_idx [COLS_PER_CYCLE];
  logic [31:0]  col_in  [COLS_PER_CYCLE];
  logic [31:0]  col_out [COLS_PER_CYCLE];
`ifdef INV_MC_FWD_MODE_EN
  logic         fwd_q;
`endif

  assign mc.state_out = st_q;

  // Column c lives at st_q[(3-c)*32 +: 32]; ~c is 3-c for a 2-bit index.
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign col_idx[g] = col_cnt + 2'(g);
    assign col_in[g]  = st_q[{~col_idx[g], 5'b00000} +: 32];

    inv_mix_column_32bit u_col (
      .col (col_in[g]),
`ifdef INV_MC_FWD_MODE_EN
      .fwd (fwd_q),
`endif
      .res (col_out[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    mc.in_ready  = 1'b0;
    mc.out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        mc.in_ready = 1'b1;
        if (mc.in_valid) state_d = BUSY;
      end
      BUSY: begin
        if (col_cnt == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        mc.out_valid = 1'b1;
        if (mc.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_cnt <= 2'd0;
      st_q    <= '0;
`ifdef INV_MC_FWD_MODE_EN
      fwd_q   <= 1'b0;
`endif
    end else if (state_q == IDLE && mc.in_valid) begin
      col_cnt <= 2'd0;
      st_q    <= mc.state_in;
`ifdef INV_MC_FWD_MODE_EN
      fwd_q   <= mc.fwd;
`endif
    end else if (state_q == BUSY) begin
      for (int g = 0; g < COLS_PER_CYCLE; g++) begin
        st_q[{~col_idx[g], 5'b00000} +: 32] <= col_out[g];
      end
      col_cnt <= col_cnt + CNT_STEP;
    end
  end

endmodule

// File: tb/tb_inv_mixcolumn_seq.sv
// Directed bench for inv_mixcolumn_seq at COLS_PER_CYCLE 1, 2 and 4; the
// round-trip scenario is built only with INV_MC_FWD_MODE_EN.
module tb_inv_mixcolumn_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inv_mixcolumn_seq_if bus1 ();
  inv_mixcolumn_seq_if bus2 ();
  inv_mixcolumn_seq_if bus4 ();

  inv_mixcolumn_seq #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .mc(bus1.slave));
  inv_mixcolumn_seq #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .mc(bus2.slave));
  inv_mixcolumn_seq #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .mc(bus4.slave));

  logic         iv   [3];
  logic         ordy [3];
  logic [127:0] sin  [3];
  logic         ir   [3];
  logic         ov   [3];
  logic [127:0] sout [3];

  assign bus1.in_valid = iv[0];  assign bus1.out_ready = ordy[0];  assign bus1.state_in = sin[0];
  assign bus2.in_valid = iv[1];  assign bus2.out_ready = ordy[1];  assign bus2.state_in = sin[1];
  assign bus4.in_valid = iv[2];  assign bus4.out_ready = ordy[2];  assign bus4.state_in = sin[2];
  assign ir[0] = bus1.in_ready;  assign ov[0] = bus1.out_valid;   assign sout[0] = bus1.state_out;
  assign ir[1] = bus2.in_ready;  assign ov[1] = bus2.out_valid;   assign sout[1] = bus2.state_out;
  assign ir[2] = bus4.in_ready;  assign ov[2] = bus4.out_valid;   assign sout[2] = bus4.state_out;

`ifdef INV_MC_FWD_MODE_EN
  logic fwdv [3];
  assign bus1.fwd = fwdv[0];
  assign bus2.fwd = fwdv[1];
  assign bus4.fwd = fwdv[2];
`endif

  int total = 0;
  int bad   = 0;

  // Hand-derived pairs: each column maps under InvMixColumns as listed.
  localparam logic [127:0] S1 = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
  localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
  localparam logic [127:0] S2 = 128'h4d7ebdf8_c6c6c6c6_00000000_8e4da1bc;
  localparam logic [127:0] E2 = 128'h2d26314c_c6c6c6c6_00000000_db135345;
  localparam logic [127:0] S3 = 128'hd5d5d7d6_4d7ebdf8_9fdc589d_01010101;
  localparam logic [127:0] E3 = 128'hd4d4d4d5_2d26314c_f20a225c_01010101;
  localparam logic [127:0] S5 = 128'hc6c6c6c6_d5d5d7d6_8e4da1bc_4d7ebdf8;
  localparam logic [127:0] E5 = 128'hc6c6c6c6_d4d4d4d5_db135345_2d26314c;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [127:0] din);
    logic acc;
    int   guard;
    acc   = 1'b0;
    guard = 0;
    sin[k] = din;
    iv[k]  = 1'b1;
    while (!acc && guard < 20) begin
      acc = ir[k];
      cyc();
      guard++;
    end
    iv[k] = 1'b0;
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL accept_timeout dut=%0d in_ready never high within %0d cycles", k, guard);
    end
  endtask

  task automatic xact(input int k, input logic [127:0] din, output logic [127:0] dout, output int lat);
    push(k, din);
    lat = 0;
    do begin
      cyc();
      lat++;
    end while (!ov[k] && lat < 20);
    dout    = sout[k];
    ordy[k] = 1'b1;
    cyc();
    ordy[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (ir[k] !== 1'b1) begin bad++; $display("FAIL reset_in_ready dut=%0d got=%b exp=1", k, ir[k]); end
      total++;
      if (ov[k] !== 1'b0) begin bad++; $display("FAIL reset_out_valid dut=%0d got=%b exp=0", k, ov[k]); end
      total++;
      if (sout[k] !== 128'h0) begin bad++; $display("FAIL reset_state_out dut=%0d got=%h exp=0", k, sout[k]); end
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_known_vector();
    logic [127:0] d;
    int           lat;
    for (int k = 0; k < 3; k++) begin
      xact(k, S1, d, lat);
      total++;
      if (d !== E1) begin bad++; $display("FAIL known_vector dut=%0d got=%h exp=%h", k, d, E1); end
      total++;
      if (lat != (4 >> k)) begin bad++; $display("FAIL known_latency dut=%0d got=%0d exp=%0d", k, lat, 4 >> k); end
    end
  endtask

  task automatic test_fixed_points();
    logic [127:0] d;
    int           lat;
    xact(0, 128'hc6c6c6c6_01010101_c6c6c6c6_01010101, d, lat);
    total++;
    if (d !== 128'hc6c6c6c6_01010101_c6c6c6c6_01010101) begin
      bad++; $display("FAIL fixed_point got=%h exp=c6c6c6c601010101c6c6c6c601010101", d);
    end
    xact(0, 128'h0, d, lat);
    total++;
    if (d !== 128'h0) begin bad++; $display("FAIL zero_state got=%h exp=0", d); end
  endtask

  task automatic test_backpressure();
    int wait_cyc;
    push(0, S2);
    wait_cyc = 0;
    while (!ov[0] && wait_cyc < 20) begin cyc(); wait_cyc++; end
    sin[0]  = S3;
    iv[0]   = 1'b1;
    ordy[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (ov[0] !== 1'b1) begin bad++; $display("FAIL bp_out_valid cycle=%0d got=%b exp=1", i, ov[0]); end
      total++;
      if (ir[0] !== 1'b0) begin bad++; $display("FAIL bp_in_ready cycle=%0d got=%b exp=0", i, ir[0]); end
      total++;
      if (sout[0] !== E2) begin bad++; $display("FAIL bp_state_out cycle=%0d got=%h exp=%h", i, sout[0], E2); end
      cyc();
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b1;
    cyc();
    ordy[0] = 1'b0;
    total++;
    if (ov[0] !== 1'b0) begin bad++; $display("FAIL bp_release_out_valid got=%b exp=0", ov[0]); end
    repeat (6) cyc();
    total++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      bad++; $display("FAIL bp_ignored_input out_valid=%b in_ready=%b exp 0/1", ov[0], ir[0]);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [127:0] d;
    int           lat;
    push(0, S1);
    cyc();
    rst_n = 1'b0;
    cyc();
    total++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
      bad++; $display("FAIL mid_busy_reset out_valid=%b in_ready=%b exp 0/1", ov[0], ir[0]);
    end
    total++;
    if (sout[0] !== 128'h0) begin bad++; $display("FAIL mid_busy_reset_state got=%h exp=0", sout[0]); end
    rst_n = 1'b1;
    cyc();
    xact(0, 128'h4d7ebdf8_00000000_00000000_00000000, d, lat);
    total++;
    if (d !== 128'h2d26314c_00000000_00000000_00000000) begin
      bad++; $display("FAIL post_reset_vector got=%h exp=2d26314c000000000000000000000000", d);
    end
    total++;
    if (lat != 4) begin bad++; $display("FAIL post_reset_latency got=%0d exp=4", lat); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] bb_in  [5];
    logic [127:0] bb_exp [5];
    logic [127:0] cap;
    logic         acc;
    logic         hs;
    int           ni;
    int           no;
    int           cycles;
    int           last_out;
    bb_in  = '{S1, S2, S3, 128'h0, S5};
    bb_exp = '{E1, E2, E3, 128'h0, E5};
    ni = 0; no = 0; cycles = 0; last_out = -1;
    sin[0]  = bb_in[0];
    iv[0]   = 1'b1;
    ordy[0] = 1'b1;
    while (no < 5 && cycles < 200) begin
      acc = iv[0] && ir[0];
      hs  = ov[0] && ordy[0];
      cap = sout[0];
      cyc();
      cycles++;
      if (acc) begin
        ni++;
        if (ni < 5) sin[0] = bb_in[ni];
        else        iv[0]  = 1'b0;
      end
      if (hs) begin
        total++;
        if (cap !== bb_exp[no]) begin bad++; $display("FAIL b2b_data idx=%0d got=%h exp=%h", no, cap, bb_exp[no]); end
        if (last_out >= 0) begin
          total++;
          if (cycles - last_out != 6) begin
            bad++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=6", no, cycles - last_out);
          end
        end
        last_out = cycles;
        no++;
      end
    end
    iv[0]   = 1'b0;
    ordy[0] = 1'b0;
    total++;
    if (no != 5) begin bad++; $display("FAIL b2b_count got=%0d exp=5", no); end
    cyc();
  endtask

`ifdef INV_MC_FWD_MODE_EN
  task automatic test_fwd_round_trip();
    logic [127:0] x;
    logic [127:0] y;
    logic [127:0] z;
    int           lat;
    fwdv[0] = 1'b1;
    xact(0, E1, y, lat);
    total++;
    if (y !== S1) begin bad++; $display("FAIL fwd_vector got=%h exp=%h", y, S1); end
    total++;
    if (lat != 4) begin bad++; $display("FAIL fwd_latency got=%0d exp=4", lat); end
    fwdv[0] = 1'b0;
    xact(0, y, z, lat);
    total++;
    if (z !== E1) begin bad++; $display("FAIL fwd_back_inv got=%h exp=%h", z, E1); end
    for (int i = 0; i < 100; i++) begin
      x = {$urandom(), $urandom(), $urandom(), $urandom()};
      fwdv[0] = 1'b1;
      xact(0, x, y, lat);
      fwdv[0] = 1'b0;
      xact(0, y, z, lat);
      total++;
      if (z !== x) begin bad++; $display("FAIL round_trip idx=%0d got=%h exp=%h", i, z, x); end
    end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      iv[k]   = 1'b0;
      ordy[k] = 1'b0;
      sin[k]  = '0;
`ifdef INV_MC_FWD_MODE_EN
      fwdv[k] = 1'b0;
`endif
    end
    rst_n = 1'b0;
    test_reset();
    test_known_vector();
    test_fixed_points();
    test_backpressure();
    test_reset_mid_busy();
    test_back_to_back();
`ifdef INV_MC_FWD_MODE_EN
    test_fwd_round_trip();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
